// File: rtl/sync_fifo_buffer_pkg.sv
// sync_fifo_buffer_pkg: sizing helper shared by the FIFO and its instantiators
package sync_fifo_buffer_pkg;

    // Pointer carries one extra wrap bit above the index so full and empty can be told apart
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_buffer.sv
// sync_fifo_buffer: single-clock byte FIFO with selectable first-word-fall-through or registered read
module sync_fifo_buffer
    import sync_fifo_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter bit FWFT_MODE  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  write_i,
    input  logic                  read_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [AW-1:0]         wr_idx, rd_idx;
    logic                  wr_ok, rd_ok;

    assign wr_idx  = wr_ptr[AW-1:0];
    assign rd_idx  = rd_ptr[AW-1:0];
    assign empty_o = wr_ptr == rd_ptr;
    assign full_o  = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
    // A write into a full FIFO is still accepted when the same edge pops a word
    assign wr_ok   = write_i && (!full_o || read_i);
    assign rd_ok   = read_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_ok) mem[wr_idx] <= wr_data_i;
    end

    generate
        if (FWFT_MODE) begin : g_fwft
            assign rd_data_o = empty_o ? '0 : mem[rd_idx];
        end else begin : g_std
            always_ff @(posedge clk_i) begin
                if (rst_i) rd_data_o <= '0;
                else if (rd_ok) rd_data_o <= mem[rd_idx];
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_buffer.sv
// tb_sync_fifo_buffer: vector table plus randomized run against a queue model, both read modes in parallel
module tb_sync_fifo_buffer;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0, write = 1'b0, read = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] fw_data, sd_data;
    logic       fw_full, fw_empty, sd_full, sd_empty;

    int passed = 0, total = 0;
    logic [7:0] q[$];
    logic [7:0] std_exp = 8'h00;

    always #5 clk = ~clk;

    sync_fifo_buffer #(.DATA_WIDTH(8), .DEPTH(D), .FWFT_MODE(1)) u_fwft (
        .clk_i(clk), .rst_i(rst), .wr_data_i(wr_data), .write_i(write), .read_i(read),
        .rd_data_o(fw_data), .full_o(fw_full), .empty_o(fw_empty)
    );

    sync_fifo_buffer #(.DATA_WIDTH(8), .DEPTH(D), .FWFT_MODE(0)) u_std (
        .clk_i(clk), .rst_i(rst), .wr_data_i(wr_data), .write_i(write), .read_i(read),
        .rd_data_o(sd_data), .full_o(sd_full), .empty_o(sd_empty)
    );

    typedef struct {
        logic       rs, w, r;
        logic [7:0] d;
        logic       e, f;
        logic       chk_fw;
        logic [7:0] fw, sd;
    } vec_t;

    vec_t tbl[23];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Queue model: the pop happens before the push, so a full FIFO accepts a write on a read edge
    task automatic tick(input logic rs, input logic w, input logic r, input logic [7:0] d);
        logic was_full, was_empty;
        rst = rs; write = w; read = r; wr_data = d;
        @(posedge clk);
        was_full  = q.size() == D;
        was_empty = q.size() == 0;
        if (rs) begin
            q.delete();
            std_exp = 8'h00;
        end else begin
            if (r && !was_empty) begin
                std_exp = q[0];
                void'(q.pop_front());
            end
            if (w && (!was_full || r)) q.push_back(d);
        end
        #1;
    endtask

    task automatic check_model();
        check("fwft_empty", {7'd0, fw_empty}, {7'd0, q.size() == 0});
        check("fwft_full",  {7'd0, fw_full},  {7'd0, q.size() == D});
        check("std_empty",  {7'd0, sd_empty}, {7'd0, q.size() == 0});
        check("std_full",   {7'd0, sd_full},  {7'd0, q.size() == D});
        if (q.size() != 0) check("fwft_data", fw_data, q[0]);
        check("std_data", sd_data, std_exp);
    endtask

    initial begin
        //          rs    w     r     d      e     f     chk   fw     sd
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h00};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'hA5};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'hA5};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 8'h11, 8'hA5};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 8'hA5};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1, 8'h11, 8'hA5};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h44, 1'b0, 1'b1, 1'b1, 8'h11, 8'hA5};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 8'h11, 8'hA5};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 8'h99, 1'b0, 1'b1, 1'b1, 8'h22, 8'h11};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h33, 8'h22};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h44, 8'h33};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h99, 8'h44};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h99};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 8'h77, 8'h99};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h77};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 8'h77};
        tbl[18] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h3C};
        tbl[19] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h3C};
        tbl[20] = '{1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A, 8'h3C};
        tbl[21] = '{1'b1, 1'b1, 1'b0, 8'h66, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00};
        tbl[22] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00};

        foreach (tbl[i]) begin
            tick(tbl[i].rs, tbl[i].w, tbl[i].r, tbl[i].d);
            check($sformatf("v%0d_fw_empty", i), {7'd0, fw_empty}, {7'd0, tbl[i].e});
            check($sformatf("v%0d_fw_full", i),  {7'd0, fw_full},  {7'd0, tbl[i].f});
            check($sformatf("v%0d_sd_empty", i), {7'd0, sd_empty}, {7'd0, tbl[i].e});
            check($sformatf("v%0d_sd_full", i),  {7'd0, sd_full},  {7'd0, tbl[i].f});
            if (tbl[i].chk_fw) check($sformatf("v%0d_fw_data", i), fw_data, tbl[i].fw);
            check($sformatf("v%0d_sd_data", i), sd_data, tbl[i].sd);
        end

        // Wrap-around: ten words streamed with two kept queued, forcing several pointer wraps
        tick(1'b0, 1'b1, 1'b0, 8'h01);
        tick(1'b0, 1'b1, 1'b0, 8'h02);
        for (int k = 3; k <= 10; k++) begin
            tick(1'b0, 1'b1, 1'b1, 8'(k));
            check("wrap_fw_data", fw_data, 8'(k - 1));
            check("wrap_sd_data", sd_data, 8'(k - 2));
            check_model();
        end
        tick(1'b0, 1'b0, 1'b1, 8'h00);
        check("wrap_sd_9", sd_data, 8'h09);
        tick(1'b0, 1'b0, 1'b1, 8'h00);
        check("wrap_sd_10", sd_data, 8'h0A);
        check("wrap_empty", {7'd0, fw_empty}, 8'h01);

        for (int n = 0; n < 600; n++) begin
            tick($urandom_range(0, 49) == 0, 1'($urandom), 1'($urandom), 8'($urandom));
            check_model();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
